// File: rtl/dsp_pipe_pkg.sv
// Shared definitions for the DSP pipeline clock-enable controller.
// NSTAGES_MAX  : upper bound on the number of controlled REG_MUX stages.
// pipe_latency : number of registered stages in a register/bypass mask,
//                i.e. the item latency through the chain in clock edges.
package dsp_pipe_pkg;

    localparam int NSTAGES_MAX = 8;

    function automatic int unsigned pipe_latency(input logic [NSTAGES_MAX-1:0] mask);
        int unsigned n;
        n = 0;
        for (int i = 0; i < NSTAGES_MAX; i++) begin
            n = n + {31'b0, mask[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/pipe_ce_ctrl_if.sv
// Valid/ready stream handshake seen by the pipeline controller.
// in_valid/in_ready  : upstream side (stage-0 D inputs).
// out_valid/out_ready: downstream side (last-stage Q outputs).
// slave  : the controller's view.
// master : the view of whatever surrounds the controller.
interface pipe_ce_ctrl_if;

    logic in_valid;
    logic in_ready;
    logic out_valid;
    logic out_ready;

    modport slave (
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_valid
    );

    modport master (
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_valid
    );

endinterface

// File: rtl/pipe_ce_stage.sv
// One stage of the clock-enable chain.
// REG = 1: the stage holds a valid flop that follows the REG_MUX register.
// REG = 0: the stage is a combinational passthrough; valid and advance
//          pass straight through and its clock enable stays low.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   flush      synchronous pipeline clear
//   ve_prev    effective valid of the previous stage (or in_valid)
//   adv_next   advance of the next stage (or out_ready)
//   ve         effective valid presented by this stage
//   adv        this stage can take new contents this cycle
//   ce         clock enable for this stage's REG_MUX
//   v          stage valid flag (0 when bypassed)
module pipe_ce_stage #(
    parameter bit REG = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic ve_prev,
    input  logic adv_next,
    output logic ve,
    output logic adv,
    output logic ce,
    output logic v
);

    logic v_q;

    always_comb begin
        ve  = ve_prev;
        adv = adv_next;
        ce  = 1'b0;
        v   = 1'b0;
        if (REG) begin
            ve  = v_q;
            // An empty stage can always load, which is what collapses bubbles
            // even while everything downstream is stalled.
            adv = ~v_q | adv_next;
            ce  = adv & ~flush & ~rst;
            v   = v_q;
        end
    end

    // With REG = 0 the enable is tied low, so this flop never leaves zero.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            v_q <= 1'b0;
        end else if (ce) begin
            v_q <= ve_prev;
        end
    end

endmodule

// File: rtl/pipe_ce_ctrl.sv
// Clock-enable and valid-tracking controller for a chain of REG_MUX stages.
// Each stage is either registered or bypassed (REG_MASK), so latency equals
// the number of registered stages. Stalls hold data via per-stage enables,
// and empty stages refill at the next edge regardless of downstream.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   flush        synchronous clear of all stage valids
//   hs           valid/ready handshake (slave view)
//   ce           per-stage clock enable, to REG_MUX clk_en
//   stage_valid  per-stage valid, 0 for bypassed stages
//   occupancy    number of valid registered stages
module pipe_ce_ctrl
    import dsp_pipe_pkg::*;
#(
    parameter int                NSTAGES  = 4,
    parameter logic [NSTAGES-1:0] REG_MASK = '1,
    parameter int                CW       = $clog2(NSTAGES + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    pipe_ce_ctrl_if.slave      hs,
    output logic [NSTAGES-1:0] ce,
    output logic [NSTAGES-1:0] stage_valid,
    output logic [CW-1:0]      occupancy
);

    localparam int unsigned LAT = pipe_latency(NSTAGES_MAX'(REG_MASK));

    // ve_c[i] is the effective valid entering stage i; ve_c[NSTAGES] leaves
    // the chain. adv_c[i] is stage i's advance; adv_c[NSTAGES] is out_ready.
    logic [NSTAGES:0] ve_c;
    logic [NSTAGES:0] adv_c;

    assign ve_c[0]        = hs.in_valid;
    assign adv_c[NSTAGES] = hs.out_ready;

    for (genvar i = 0; i < NSTAGES; i++) begin : g_stage
        pipe_ce_stage #(
            .REG (REG_MASK[i])
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .ve_prev  (ve_c[i]),
            .adv_next (adv_c[i+1]),
            .ve       (ve_c[i+1]),
            .adv      (adv_c[i]),
            .ce       (ce[i]),
            .v        (stage_valid[i])
        );
    end

    assign hs.in_ready  = adv_c[0] & ~flush & ~rst;
    assign hs.out_valid = ve_c[NSTAGES] & ~flush & ~rst;

    if (LAT == 0) begin : g_occ_comb
        // Fully combinational chain: nothing is ever held.
        assign occupancy = '0;
    end else begin : g_occ_cnt
        logic accept;
        logic emit;

        assign accept = hs.in_valid & hs.in_ready;
        assign emit   = hs.out_valid & hs.out_ready;

        // flush already masks accept and emit, but the clear must win anyway.
        always_ff @(posedge clk) begin
            if (rst || flush) begin
                occupancy <= '0;
            end else if (accept && !emit) begin
                occupancy <= occupancy + CW'(1);
            end else if (emit && !accept) begin
                occupancy <= occupancy - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_ce_ctrl.sv
// Directed bench for pipe_ce_ctrl: one instance fully registered (1111),
// one with stages 0 and 2 bypassed (1010).
module tb_pipe_ce_ctrl;

    logic       clk;
    logic       rst;
    logic       flush_a;
    logic       flush_b;
    logic [3:0] ce_a, sv_a, ce_b, sv_b;
    logic [2:0] occ_a, occ_b;

    int checks;
    int errors;
    int emits;

    int occ_tab [16] = '{0, 1, 2, 3, 4, 4, 4, 4, 4, 4, 4, 3, 2, 1, 0, 0};

    pipe_ce_ctrl_if ha ();
    pipe_ce_ctrl_if hb ();

    pipe_ce_ctrl #(.NSTAGES(4), .REG_MASK(4'b1111)) dut_a (
        .clk(clk), .rst(rst), .flush(flush_a), .hs(ha),
        .ce(ce_a), .stage_valid(sv_a), .occupancy(occ_a)
    );

    pipe_ce_ctrl #(.NSTAGES(4), .REG_MASK(4'b1010)) dut_b (
        .clk(clk), .rst(rst), .flush(flush_b), .hs(hb),
        .ce(ce_b), .stage_valid(sv_b), .occupancy(occ_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Move to just after the next rising edge, where inputs are changed.
    task automatic edge_a();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic iv, input logic ordy);
        ha.in_valid  = iv;
        ha.out_ready = ordy;
    endtask

    task automatic set_b(input logic iv, input logic ordy);
        hb.in_valid  = iv;
        hb.out_ready = ordy;
    endtask

    task automatic chk_b_bypass();
        chk("b_sv_bypass", 8'(sv_b & 4'b0101), 8'h00);
        chk("b_ce_bypass", 8'(ce_b & 4'b0101), 8'h00);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        emits   = 0;
        rst     = 1'b1;
        flush_a = 1'b0;
        flush_b = 1'b0;
        set_a(1'b1, 1'b1);
        set_b(1'b0, 1'b0);

        // Reset held for two edges with in_valid high
        edge_a();
        @(negedge clk);
        chk("rst_ce", 8'(ce_a), 8'h00);
        chk("rst_in_ready", 8'(ha.in_ready), 8'h00);
        chk("rst_out_valid", 8'(ha.out_valid), 8'h00);
        chk("rst_occ", 8'(occ_a), 8'h00);
        chk("rst_sv", 8'(sv_a), 8'h00);
        edge_a();
        rst = 1'b0;
        set_a(1'b0, 1'b1);
        @(negedge clk);
        chk("post_rst_in_ready", 8'(ha.in_ready), 8'h01);
        chk("post_rst_ce", 8'(ce_a), 8'h0f);
        chk("post_rst_occ", 8'(occ_a), 8'h00);

        // Streaming: 10 items, out_ready held high
        for (int c = 0; c < 16; c++) begin
            edge_a();
            set_a(c < 10, 1'b1);
            @(negedge clk);
            chk($sformatf("stream_occ_%0d", c), 8'(occ_a), 8'(occ_tab[c]));
            chk($sformatf("stream_ov_%0d", c), 8'(ha.out_valid), 8'((c >= 4) && (c <= 13)));
            if (ha.out_valid && ha.out_ready) emits++;
        end
        chk("stream_emits", 8'(emits), 8'd10);

        // Stall: fill with out_ready low
        for (int s = 0; s < 4; s++) begin
            edge_a();
            set_a(1'b1, 1'b0);
            @(negedge clk);
            chk($sformatf("fill_in_ready_%0d", s), 8'(ha.in_ready), 8'h01);
            chk($sformatf("fill_occ_%0d", s), 8'(occ_a), 8'(s));
        end
        edge_a();
        set_a(1'b1, 1'b0);
        @(negedge clk);
        chk("full_in_ready", 8'(ha.in_ready), 8'h00);
        chk("full_ce", 8'(ce_a), 8'h00);
        chk("full_occ", 8'(occ_a), 8'h04);
        chk("full_sv", 8'(sv_a), 8'h0f);
        chk("full_out_valid", 8'(ha.out_valid), 8'h01);
        edge_a();
        set_a(1'b1, 1'b1);
        @(negedge clk);
        chk("release_ce", 8'(ce_a), 8'h0f);
        chk("release_in_ready", 8'(ha.in_ready), 8'h01);
        chk("release_out_valid", 8'(ha.out_valid), 8'h01);
        edge_a();
        set_a(1'b1, 1'b0);
        @(negedge clk);
        chk("after_release_occ", 8'(occ_a), 8'h04);
        chk("after_release_ce", 8'(ce_a), 8'h00);

        // Drain to empty
        for (int d = 0; d < 4; d++) begin
            edge_a();
            set_a(1'b0, 1'b1);
        end
        edge_a();
        set_a(1'b0, 1'b0);
        @(negedge clk);
        chk("empty_occ", 8'(occ_a), 8'h00);
        chk("empty_out_valid", 8'(ha.out_valid), 8'h00);

        // Bubble collapse: build items at stages 0 and 3
        edge_a(); set_a(1'b1, 1'b0);
        edge_a(); set_a(1'b0, 1'b0);
        edge_a(); set_a(1'b0, 1'b0);
        edge_a(); set_a(1'b0, 1'b0);
        edge_a(); set_a(1'b1, 1'b0);
        @(negedge clk);
        chk("bub_sv_1000", 8'(sv_a), 8'h08);
        edge_a(); set_a(1'b0, 1'b0);
        @(negedge clk);
        chk("bub_sv_1001", 8'(sv_a), 8'h09);
        chk("bub_ce_0111", 8'(ce_a), 8'h07);
        edge_a(); set_a(1'b1, 1'b0);
        @(negedge clk);
        chk("bub_sv_1010", 8'(sv_a), 8'h0a);
        chk("bub_occ_2", 8'(occ_a), 8'h02);

        // Flush with occupancy 3 and in_valid high
        edge_a();
        set_a(1'b1, 1'b1);
        flush_a = 1'b1;
        @(negedge clk);
        chk("flush_occ_before", 8'(occ_a), 8'h03);
        chk("flush_sv_before", 8'(sv_a), 8'h0d);
        chk("flush_in_ready", 8'(ha.in_ready), 8'h00);
        chk("flush_out_valid", 8'(ha.out_valid), 8'h00);
        chk("flush_ce", 8'(ce_a), 8'h00);
        edge_a();
        flush_a = 1'b0;
        set_a(1'b1, 1'b0);
        @(negedge clk);
        chk("flush_occ_after", 8'(occ_a), 8'h00);
        chk("flush_sv_after", 8'(sv_a), 8'h00);

        // rst and flush together
        edge_a();
        rst     = 1'b1;
        flush_a = 1'b1;
        set_a(1'b1, 1'b1);
        @(negedge clk);
        chk("rstflush_occ_before", 8'(occ_a), 8'h01);
        chk("rstflush_ce", 8'(ce_a), 8'h00);
        chk("rstflush_in_ready", 8'(ha.in_ready), 8'h00);
        chk("rstflush_out_valid", 8'(ha.out_valid), 8'h00);
        edge_a();
        rst     = 1'b0;
        flush_a = 1'b0;
        set_a(1'b0, 1'b1);
        @(negedge clk);
        chk("rstflush_occ_after", 8'(occ_a), 8'h00);
        chk("rstflush_sv_after", 8'(sv_a), 8'h00);
        chk("rstflush_in_ready", 8'(ha.in_ready), 8'h01);
        set_a(1'b0, 1'b0);

        // Bypass configuration 1010: latency 2
        edge_a(); set_b(1'b1, 1'b1);
        @(negedge clk);
        chk("b_ce_first", 8'(ce_b), 8'h0a);
        chk("b_in_ready", 8'(hb.in_ready), 8'h01);
        chk("b_ov_0", 8'(hb.out_valid), 8'h00);
        chk_b_bypass();
        edge_a(); set_b(1'b0, 1'b1);
        @(negedge clk);
        chk("b_sv_0010", 8'(sv_b), 8'h02);
        chk("b_occ_1", 8'(occ_b), 8'h01);
        chk("b_ov_1", 8'(hb.out_valid), 8'h00);
        chk_b_bypass();
        edge_a(); set_b(1'b0, 1'b1);
        @(negedge clk);
        chk("b_ov_2", 8'(hb.out_valid), 8'h01);
        chk("b_sv_1000", 8'(sv_b), 8'h08);
        chk("b_ce_emit", 8'(ce_b), 8'h0a);
        chk_b_bypass();
        edge_a(); set_b(1'b1, 1'b0);
        @(negedge clk);
        chk("b_ov_3", 8'(hb.out_valid), 8'h00);
        chk("b_occ_0", 8'(occ_b), 8'h00);
        edge_a(); set_b(1'b1, 1'b0);
        @(negedge clk);
        chk("b_occ_fill1", 8'(occ_b), 8'h01);
        chk_b_bypass();
        edge_a(); set_b(1'b1, 1'b0);
        @(negedge clk);
        chk("b_full_in_ready", 8'(hb.in_ready), 8'h00);
        chk("b_full_ce", 8'(ce_b), 8'h00);
        chk("b_full_occ", 8'(occ_b), 8'h02);
        chk("b_full_sv", 8'(sv_b), 8'h0a);
        chk("b_full_ov", 8'(hb.out_valid), 8'h01);
        chk_b_bypass();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ce_ctrl.md
Name: pipe_ce_ctrl

Overview:
Clock-enable and valid-tracking controller that drives the clk_en inputs of a chain of REG_MUX pipeline stages in the DSP48A1 datapath.
It sits on the control side of the register chain: it accepts a valid/ready stream at the input and presents one at the output.
It generates one clock enable per stage so the pipeline stalls without losing data, and it squeezes bubbles out of the chain.
Per-stage register/bypass selection mirrors the REG_MUX register parameter, so the controller's latency tracks the datapath configuration.

Parameters:
NSTAGES, 4, number of REG_MUX stages controlled (1..8).
REG_MASK, 4'b1111 (NSTAGES bits), bit i = 1 means stage i is registered; 0 means bypassed (combinational passthrough).
CW, $clog2(NSTAGES+1), width of the occupancy counter.

Ports:
clk  in  1  rising-edge clock shared with the datapath.
rst  in  1  synchronous, active-high reset.
flush  in  1  synchronous pipeline clear.
in_valid  in  1  upstream has data on the stage-0 D inputs.
in_ready  out  1  controller accepts the input this cycle.
out_ready  in  1  downstream takes the last-stage output this cycle.
out_valid  out  1  the last-stage Q output holds valid data.
ce  out  NSTAGES  per-stage clock enable, driving REG_MUX clk_en.
stage_valid  out  NSTAGES  valid flag per stage; always 0 for bypassed stages.
occupancy  out  CW  number of valid registered stages.

Behaviour:
- Reset: rst = 1 at a rising edge clears all valid flops and occupancy to 0.
  - While rst is high: ce = 0, in_ready = 0, out_valid = 0.
  - rst dominates flush.
- Effective valid, ve[i]:
  - Registered stage: v[i] (flop).
  - Bypassed stage: ve[i-1].
  - ve[-1] = in_valid.
- Advance, adv[i]:
  - Terminal: adv[NSTAGES] = out_ready.
  - Registered stage: adv[i] = ~v[i] | adv[i+1].
  - Bypassed stage: adv[i] = adv[i+1].
- Outputs:
  - ce[i] = adv[i] & REG_MASK[i] & ~flush & ~rst.
  - When ce[i] = 1: v[i] <= ve[i-1]. Bubbles are loaded as valid = 0, and the data loaded with a bubble is don't-care.
  - in_ready = adv[0] & ~flush & ~rst.
  - out_valid = ve[NSTAGES-1] & ~flush & ~rst.
- Transfers:
  - Accept occurs when in_valid & in_ready.
  - Emit occurs when out_valid & out_ready.
- Latency: L = popcount(REG_MASK). With out_ready held high, an item accepted at edge k presents out_valid after edge k+L-1, i.e. it is emitted in the cycle after edge k+L-1.
  - With L = 0 the block is fully combinational: out_valid = in_valid and in_ready = out_ready.
- Throughput: one item per cycle when out_ready stays high. A bubble in stage i is filled at the next edge even while downstream is stalled.
- Full: all registered stages valid and out_ready = 0 gives in_ready = 0 and ce = 0.
- Empty: occupancy = 0 and out_valid = 0; this only holds when the last registered stage is invalid.
- occupancy:
  - +1 on accept without emit; -1 on emit without accept; unchanged on both or neither.
  - It must equal popcount(v & REG_MASK) every cycle, and it never exceeds L.
- flush: at the edge, all v are cleared and occupancy goes to 0. That cycle has no accept and no emit.
  - When flush and in_valid are high together, the input is dropped and in_ready reads 0.
- Combinational paths: out_ready -> in_ready and out_ready -> ce ripple through all stages. This is intentional; the maximum depth is 8.

Decomposition:
- Package dsp_pipe_pkg: a function computing the latency L from REG_MASK; NSTAGES_MAX = 8.
- Sub-module pipe_ce_stage: one stage's valid flop plus its adv/ce logic, with a REG parameter. It is instantiated NSTAGES times in a generate loop.
- The occupancy counter stays in the top level.

Test Plan:
1. Reset: rst = 1 for 2 cycles with in_valid = 1 -> ce = 0000, in_ready = 0, out_valid = 0, occupancy = 0. After release, in_ready = 1 on the first cycle.
2. Streaming, REG_MASK = 1111, out_ready = 1, in_valid = 1 for 10 cycles -> first out_valid after 4 edges, then 10 consecutive emits. occupancy steps 1, 2, 3, 4, stays at 4, then drains to 0.
3. Stall: fill 4 items with out_ready = 0 -> in_ready = 0, ce = 0000, occupancy = 4. Raise out_ready for 1 cycle -> ce = 1111, exactly one emit, occupancy stays 4 if in_valid = 1.
4. Bubble collapse: items at stages 0 and 3, out_ready = 0 -> the next edge moves stage 0 to 1, and ce = 0111 that cycle. Stage 3 holds.
5. Bypass, REG_MASK = 1010 -> latency 2. stage_valid[0] and stage_valid[2] stay 0, and ce[0] = ce[2] = 0 at all times.
6. Flush: occupancy = 3 with in_valid = 1; assert flush for 1 cycle -> in_ready = 0, out_valid = 0 that cycle, and occupancy = 0 on the next cycle. With rst and flush together, reset behaviour applies.
